// File: rtl/arith_mod_mersenne_reduct_pkg.sv
// -----------------------------------------------------------------------------
// arith_mod_mersenne_reduct_pkg
// Shared constants and helpers for the Mersenne-modulus reduction pipeline.
// Build option: ARITH_MOD_MERSENNE_CANON_EN adds the canonicalising stage, so
// the output stays in [0, M-1]. The latency helper tracks that option.
// -----------------------------------------------------------------------------
package arith_mod_mersenne_reduct_pkg;

`ifdef ARITH_MOD_MERSENNE_CANON_EN
    localparam bit CANON_EN = 1'b1;
`else
    localparam bit CANON_EN = 1'b0;
`endif

    // Widest modulus the M helper can build.
    localparam int unsigned MAX_MOD_W = 512;

    // Cycles from in_avail to out_avail for the selected build.
    function automatic int unsigned get_latency(input bit in_pipe);
        return (in_pipe ? 32'd1 : 32'd0) + 32'd2 + (CANON_EN ? 32'd1 : 32'd0);
    endfunction

    // The first fold needs one extra bit for the carry out of hi + lo.
    function automatic int unsigned get_fold_w(input int unsigned mod_w);
        return mod_w + 32'd1;
    endfunction

    // All-ones value of mod_w bits (M = 2^mod_w - 1), right-aligned.
    function automatic logic [MAX_MOD_W-1:0] get_mersenne(input int unsigned mod_w);
        return {MAX_MOD_W{1'b1}} >> (MAX_MOD_W - mod_w);
    endfunction

endpackage

// File: rtl/arith_mod_mersenne_pipe_reg.sv
// -----------------------------------------------------------------------------
// arith_mod_mersenne_pipe_reg
// One pipeline stage: data, avail and side registers.
//   clk, a_rst_n       : clock, asynchronous active-low reset
//   i_data / o_data    : stage data; updates every cycle, resets to 0
//   i_avail / o_avail  : valid flag; resets to 0
//   i_side / o_side    : side data; loaded only with a valid item, so the
//                        reset value is held until the first real item passes.
//                        RST_SIDE[0]: reset to 0, RST_SIDE[1]: reset to 1,
//                        neither: not reset.
// -----------------------------------------------------------------------------
module arith_mod_mersenne_pipe_reg #(
    parameter int          DATA_W   = 8,
    parameter int          SIDE_W   = 1,
    parameter logic [1:0]  RST_SIDE = 2'b00
) (
    input  logic              clk,
    input  logic              a_rst_n,
    input  logic [DATA_W-1:0] i_data,
    input  logic              i_avail,
    input  logic [SIDE_W-1:0] i_side,
    output logic [DATA_W-1:0] o_data,
    output logic              o_avail,
    output logic [SIDE_W-1:0] o_side
);

    logic [DATA_W-1:0] r_data;
    logic              r_avail;
    logic [SIDE_W-1:0] r_side;

    always_ff @(posedge clk or negedge a_rst_n) begin
        if (!a_rst_n) begin
            r_data  <= '0;
            r_avail <= 1'b0;
        end else begin
            r_data  <= i_data;
            r_avail <= i_avail;
        end
    end

    generate
        if (RST_SIDE[0]) begin : g_side_rst0
            always_ff @(posedge clk or negedge a_rst_n) begin
                if (!a_rst_n)     r_side <= '0;
                else if (i_avail) r_side <= i_side;
            end
        end else if (RST_SIDE[1]) begin : g_side_rst1
            always_ff @(posedge clk or negedge a_rst_n) begin
                if (!a_rst_n)     r_side <= '1;
                else if (i_avail) r_side <= i_side;
            end
        end else begin : g_side_norst
            always_ff @(posedge clk) begin
                if (i_avail) r_side <= i_side;
            end
        end
    endgenerate

    assign o_data  = r_data;
    assign o_avail = r_avail;
    assign o_side  = r_side;

endmodule

// File: rtl/arith_mod_mersenne_reduct.sv
// -----------------------------------------------------------------------------
// arith_mod_mersenne_reduct
// Pipelined reduction of a modulo M = 2^MOD_W - 1 by fold-and-add.
//   clk, a_rst_n          : clock, asynchronous active-low reset
//   a, in_avail, in_side  : input value, its valid flag, side data
//   z, out_avail, out_side: residue, its valid flag, aligned side data
// Stages: [S0 input reg if IN_PIPE] -> S1 hi+lo -> S2 carry fold
//         -> [S3 M->0 if ARITH_MOD_MERSENNE_CANON_EN]
// Without ARITH_MOD_MERSENNE_CANON_EN, z may equal M (a redundant zero).
// Side ports are one bit wide when SIDE_W = 0 and then carry nothing useful.
// -----------------------------------------------------------------------------
module arith_mod_mersenne_reduct
    import arith_mod_mersenne_reduct_pkg::*;
#(
    parameter int          IN_W     = 128,
    parameter int          MOD_W    = 64,
    parameter bit          IN_PIPE  = 1'b1,
    parameter int          SIDE_W   = 0,
    parameter logic [1:0]  RST_SIDE = 2'b00
) (
    input  logic                                  clk,
    input  logic                                  a_rst_n,
    input  logic [IN_W-1:0]                       a,
    input  logic                                  in_avail,
    output logic [MOD_W-1:0]                      z,
    output logic                                  out_avail,
    input  logic [((SIDE_W > 0) ? SIDE_W : 1)-1:0] in_side,
    output logic [((SIDE_W > 0) ? SIDE_W : 1)-1:0] out_side
);

    localparam int X2_W   = 2 * MOD_W;
    localparam int FOLD_W = int'(get_fold_w(MOD_W));
    localparam int SW     = (SIDE_W > 0) ? SIDE_W : 1;

    generate
        if (IN_W < 1 || IN_W > 2 * MOD_W) begin : g_bad_in_w
            $fatal(1, "arith_mod_mersenne_reduct: IN_W must be in [1, 2*MOD_W]");
        end
        if (MOD_W < 2 || MOD_W > int'(MAX_MOD_W)) begin : g_bad_mod_w
            $fatal(1, "arith_mod_mersenne_reduct: MOD_W out of range");
        end
    endgenerate

    logic [X2_W-1:0]   w_a_ext;
    logic [X2_W-1:0]   w_x;
    logic              w_x_avail;
    logic [SW-1:0]     w_x_side;

    assign w_a_ext = X2_W'(a);

    // S0: optional input register
    generate
        if (IN_PIPE) begin : g_s0
            arith_mod_mersenne_pipe_reg #(
                .DATA_W   (X2_W),
                .SIDE_W   (SW),
                .RST_SIDE (RST_SIDE)
            ) u_s0 (
                .clk     (clk),
                .a_rst_n (a_rst_n),
                .i_data  (w_a_ext),
                .i_avail (in_avail),
                .i_side  (in_side),
                .o_data  (w_x),
                .o_avail (w_x_avail),
                .o_side  (w_x_side)
            );
        end else begin : g_s0_bypass
            assign w_x       = w_a_ext;
            assign w_x_avail = in_avail;
            assign w_x_side  = in_side;
        end
    endgenerate

    // S1: 2^MOD_W == 1 (mod M), so hi*2^MOD_W + lo folds to hi + lo.
    logic [FOLD_W-1:0] w_f1_d;
    logic [FOLD_W-1:0] w_f1;
    logic              w_f1_avail;
    logic [SW-1:0]     w_f1_side;

    assign w_f1_d = {1'b0, w_x[X2_W-1:MOD_W]} + {1'b0, w_x[MOD_W-1:0]};

    arith_mod_mersenne_pipe_reg #(
        .DATA_W   (FOLD_W),
        .SIDE_W   (SW),
        .RST_SIDE (RST_SIDE)
    ) u_s1 (
        .clk     (clk),
        .a_rst_n (a_rst_n),
        .i_data  (w_f1_d),
        .i_avail (w_x_avail),
        .i_side  (w_x_side),
        .o_data  (w_f1),
        .o_avail (w_f1_avail),
        .o_side  (w_f1_side)
    );

    // S2: fold the single carry bit back in. When the carry is set the low
    // part is at most 2^MOD_W-2, so the sum fits in MOD_W bits.
    logic [MOD_W-1:0]  w_f2_d;
    logic [MOD_W-1:0]  w_f2;
    logic              w_f2_avail;
    logic [SW-1:0]     w_f2_side;

    assign w_f2_d = w_f1[MOD_W-1:0] + MOD_W'(w_f1[MOD_W]);

    arith_mod_mersenne_pipe_reg #(
        .DATA_W   (MOD_W),
        .SIDE_W   (SW),
        .RST_SIDE (RST_SIDE)
    ) u_s2 (
        .clk     (clk),
        .a_rst_n (a_rst_n),
        .i_data  (w_f2_d),
        .i_avail (w_f1_avail),
        .i_side  (w_f1_side),
        .o_data  (w_f2),
        .o_avail (w_f2_avail),
        .o_side  (w_f2_side)
    );

`ifdef ARITH_MOD_MERSENNE_CANON_EN
    // S3: M is the only redundant value left; map it to 0.
    localparam logic [MOD_W-1:0] M = MOD_W'(get_mersenne(MOD_W));

    logic [MOD_W-1:0]  w_z_d;

    assign w_z_d = (w_f2 == M) ? '0 : w_f2;

    arith_mod_mersenne_pipe_reg #(
        .DATA_W   (MOD_W),
        .SIDE_W   (SW),
        .RST_SIDE (RST_SIDE)
    ) u_s3 (
        .clk     (clk),
        .a_rst_n (a_rst_n),
        .i_data  (w_z_d),
        .i_avail (w_f2_avail),
        .i_side  (w_f2_side),
        .o_data  (z),
        .o_avail (out_avail),
        .o_side  (out_side)
    );
`else
    assign z         = w_f2;
    assign out_avail = w_f2_avail;
    assign out_side  = w_f2_side;
`endif

endmodule

// File: tb/tb_arith_mod_mersenne_reduct.sv
// -----------------------------------------------------------------------------
// tb_arith_mod_mersenne_reduct
// Three instances share one stimulus: the main one (IN_PIPE=1, side reset to
// 0), one without the input register, and one whose side resets to all-1.
// -----------------------------------------------------------------------------
module tb_arith_mod_mersenne_reduct;

`ifdef ARITH_MOD_MERSENNE_CANON_EN
    localparam bit CANON = 1'b1;
`else
    localparam bit CANON = 1'b0;
`endif
    localparam int LAT    = 3 + (CANON ? 1 : 0);
    localparam int LAT_NP = 2 + (CANON ? 1 : 0);
    localparam int N_RAND = 1000;

    logic        clk = 1'b0;
    logic        a_rst_n;
    logic [15:0] a;
    logic        in_avail;
    logic [3:0]  in_side;

    logic [7:0]  z_m, z_n, z_r;
    logic        av_m, av_n, av_r;
    logic [3:0]  side_m, side_n, side_r;

    int errors = 0;
    int checks = 0;

    logic [15:0] hist_a [N_RAND];
    logic        hist_v [N_RAND];
    logic [3:0]  hist_s [N_RAND];

    always #5 clk = ~clk;

    arith_mod_mersenne_reduct #(
        .IN_W(16), .MOD_W(8), .IN_PIPE(1'b1), .SIDE_W(4), .RST_SIDE(2'b01)
    ) dut_main (
        .clk(clk), .a_rst_n(a_rst_n), .a(a), .in_avail(in_avail),
        .z(z_m), .out_avail(av_m), .in_side(in_side), .out_side(side_m)
    );

    arith_mod_mersenne_reduct #(
        .IN_W(16), .MOD_W(8), .IN_PIPE(1'b0), .SIDE_W(4), .RST_SIDE(2'b01)
    ) dut_np (
        .clk(clk), .a_rst_n(a_rst_n), .a(a), .in_avail(in_avail),
        .z(z_n), .out_avail(av_n), .in_side(in_side), .out_side(side_n)
    );

    arith_mod_mersenne_reduct #(
        .IN_W(16), .MOD_W(8), .IN_PIPE(1'b1), .SIDE_W(4), .RST_SIDE(2'b10)
    ) dut_rs (
        .clk(clk), .a_rst_n(a_rst_n), .a(a), .in_avail(in_avail),
        .z(z_r), .out_avail(av_r), .in_side(in_side), .out_side(side_r)
    );

    // Reference: true residue mod 255. Without canonicalisation a nonzero
    // multiple of 255 shows up as 255 rather than 0.
    function automatic logic [7:0] ref_mod(input logic [15:0] v);
        int unsigned r;
        r = int'(v) % 255;
        if (!CANON && r == 0 && v != 16'h0) r = 255;
        return r[7:0];
    endfunction

    task automatic test_reset();
        a_rst_n  = 1'b0;
        a        = 16'h0;
        in_avail = 1'b0;
        in_side  = 4'h0;
        repeat (3) @(negedge clk);
        checks++;
        if (av_m !== 1'b0 || av_n !== 1'b0 || av_r !== 1'b0) begin
            errors++;
            $display("FAIL reset_avail: got %b%b%b want 000", av_m, av_n, av_r);
        end
        checks++;
        if (z_m !== 8'h00 || z_n !== 8'h00 || z_r !== 8'h00) begin
            errors++;
            $display("FAIL reset_z: got %h %h %h want 00", z_m, z_n, z_r);
        end
        checks++;
        if (side_m !== 4'h0 || side_r !== 4'hF) begin
            errors++;
            $display("FAIL reset_side: got %h/%h want 0/f", side_m, side_r);
        end
        a_rst_n = 1'b1;
    endtask

    task automatic test_single();
        for (int c = 0; c < LAT + 3; c++) begin
            @(posedge clk); #1;
            in_avail = (c == 0);
            a        = (c == 0) ? 16'h1234 : 16'($urandom);
            in_side  = (c == 0) ? 4'h5 : 4'($urandom);
            @(negedge clk);
            checks++;
            if (av_m !== (c == LAT)) begin
                errors++;
                $display("FAIL single_avail c=%0d: got %b want %b", c, av_m, (c == LAT));
            end
            if (c == LAT) begin
                checks++;
                if (z_m !== 8'h46 || side_m !== 4'h5) begin
                    errors++;
                    $display("FAIL single_z: got z=%h side=%h want z=46 side=5", z_m, side_m);
                end
            end
        end
    endtask

    task automatic test_boundary();
        logic [15:0] vals [5];
        logic [7:0]  expc [5];
        vals = '{16'hFFFF, 16'h00FF, 16'h0100, 16'h0000, 16'hFE01};
        if (CANON) expc = '{8'h00, 8'h00, 8'h01, 8'h00, 8'h00};
        else       expc = '{8'hFF, 8'hFF, 8'h01, 8'h00, 8'hFF};
        for (int c = 0; c < LAT + 6; c++) begin
            @(posedge clk); #1;
            in_avail = (c < 5);
            a        = (c < 5) ? vals[c] : 16'($urandom);
            in_side  = 4'(c);
            @(negedge clk);
            if (c >= LAT && c < LAT + 5) begin
                checks++;
                if (av_m !== 1'b1 || z_m !== expc[c-LAT] || side_m !== 4'(c - LAT)) begin
                    errors++;
                    $display("FAIL boundary a=%h: got av=%b z=%h side=%h want av=1 z=%h side=%h",
                             vals[c-LAT], av_m, z_m, side_m, expc[c-LAT], 4'(c - LAT));
                end
            end
        end
    endtask

    task automatic test_back_to_back();
        int bad = 0;
        for (int c = 0; c < N_RAND + LAT; c++) begin
            @(posedge clk); #1;
            if (c < N_RAND) begin
                in_avail  = ($urandom_range(0, 3) != 0);
                a         = 16'($urandom);
                in_side   = 4'($urandom);
                hist_a[c] = a;
                hist_v[c] = in_avail;
                hist_s[c] = in_side;
            end else begin
                in_avail = 1'b0;
            end
            @(negedge clk);
            if (c >= LAT) begin
                checks++;
                if (av_m !== hist_v[c-LAT]) begin
                    errors++;
                    if (bad++ < 10)
                        $display("FAIL b2b_avail item %0d: got %b want %b", c - LAT, av_m, hist_v[c-LAT]);
                end else if (hist_v[c-LAT]) begin
                    checks++;
                    if (z_m !== ref_mod(hist_a[c-LAT]) || side_m !== hist_s[c-LAT]) begin
                        errors++;
                        if (bad++ < 10)
                            $display("FAIL b2b_z a=%h: got z=%h side=%h want z=%h side=%h",
                                     hist_a[c-LAT], z_m, side_m, ref_mod(hist_a[c-LAT]), hist_s[c-LAT]);
                    end
                end
            end
        end
    endtask

    task automatic test_no_pipe();
        for (int c = 0; c < LAT_NP + 3; c++) begin
            @(posedge clk); #1;
            in_avail = (c == 0);
            a        = (c == 0) ? 16'h0201 : 16'($urandom);
            in_side  = 4'h9;
            @(negedge clk);
            checks++;
            if (av_n !== (c == LAT_NP)) begin
                errors++;
                $display("FAIL nopipe_avail c=%0d: got %b want %b", c, av_n, (c == LAT_NP));
            end
            if (c == LAT_NP) begin
                checks++;
                if (z_n !== 8'h03 || side_n !== 4'h9) begin
                    errors++;
                    $display("FAIL nopipe_z: got z=%h side=%h want z=03 side=9", z_n, side_n);
                end
            end
        end
    endtask

    task automatic test_reset_midflight();
        logic [15:0] v;
        for (int c = 0; c < 3; c++) begin
            @(posedge clk); #1;
            in_avail = 1'b1;
            a        = 16'($urandom_range(1, 16'hFFFF));
            in_side  = 4'($urandom);
        end
        @(posedge clk); #1;
        in_avail = 1'b0;
        #2 a_rst_n = 1'b0;
        #1;
        checks++;
        if (av_m !== 1'b0 || av_n !== 1'b0 || av_r !== 1'b0) begin
            errors++;
            $display("FAIL midreset_avail: got %b%b%b want 000", av_m, av_n, av_r);
        end
        checks++;
        if (z_m !== 8'h00 || z_n !== 8'h00 || z_r !== 8'h00) begin
            errors++;
            $display("FAIL midreset_z: got %h %h %h want 00", z_m, z_n, z_r);
        end
        repeat (2) @(negedge clk);
        a_rst_n = 1'b1;
        for (int c = 0; c < LAT + 3; c++) begin
            @(posedge clk); #1;
            in_avail = 1'b0;
            a        = 16'($urandom);
            @(negedge clk);
            checks++;
            if (av_m !== 1'b0 || av_n !== 1'b0) begin
                errors++;
                $display("FAIL midreset_ghost c=%0d: got %b%b want 00", c, av_m, av_n);
            end
        end
        v = 16'($urandom);
        for (int c = 0; c < LAT + 2; c++) begin
            @(posedge clk); #1;
            in_avail = (c == 0);
            a        = (c == 0) ? v : 16'($urandom);
            in_side  = 4'hA;
            @(negedge clk);
            if (c == LAT) begin
                checks++;
                if (av_m !== 1'b1 || z_m !== ref_mod(v)) begin
                    errors++;
                    $display("FAIL midreset_new a=%h: got av=%b z=%h want av=1 z=%h", v, av_m, z_m, ref_mod(v));
                end
            end
        end
    endtask

    task automatic test_rst_side();
        @(posedge clk); #1;
        in_avail = 1'b0;
        in_side  = 4'h0;
        a_rst_n  = 1'b0;
        #1;
        checks++;
        if (side_r !== 4'hF) begin
            errors++;
            $display("FAIL rstside_during: got %h want f", side_r);
        end
        @(negedge clk);
        a_rst_n = 1'b1;
        for (int c = 0; c < LAT + 2; c++) begin
            @(posedge clk); #1;
            in_avail = 1'b0;
            in_side  = 4'h0;
            @(negedge clk);
            checks++;
            if (side_r !== 4'hF) begin
                errors++;
                $display("FAIL rstside_after c=%0d: got %h want f", c, side_r);
            end
        end
        for (int c = 0; c < LAT + 1; c++) begin
            @(posedge clk); #1;
            in_avail = (c == 0);
            a        = 16'h0300;
            in_side  = (c == 0) ? 4'h3 : 4'h0;
            @(negedge clk);
            if (c == LAT) begin
                checks++;
                if (av_r !== 1'b1 || side_r !== 4'h3 || z_r !== 8'h03) begin
                    errors++;
                    $display("FAIL rstside_first: got av=%b side=%h z=%h want av=1 side=3 z=03",
                             av_r, side_r, z_r);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_boundary();
        test_back_to_back();
        test_no_pipe();
        test_reset_midflight();
        test_rst_side();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
